// File: rtl/seg_scan_display.sv
// seg_scan_display: synchronizes/debounces a position code, counts accepted
// changes in BCD and scans both values onto a 4-digit 7-segment display.
module seg_scan_display #(
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned BLANK_CYC  = 1000,
  parameter int unsigned STABLE_CYC = 4,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] code,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] disp_code,
  output logic [7:0] chg_bcd
);

  localparam int unsigned PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned STAB_W  = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(SCAN_DIV - 1);
  localparam logic [PRESC_W-1:0] BLANK_END = PRESC_W'(BLANK_CYC);
  localparam logic [STAB_W-1:0]  STAB_MAX  = STAB_W'(STABLE_CYC - 1);
  localparam logic               INV       = (ACTIVE_LOW != 0);

  // Internal glyph codes: 0..9 are digits, the rest are symbols.
  localparam logic [3:0] G_DASH  = 4'hA;
  localparam logic [3:0] G_E     = 4'hE;
  localparam logic [3:0] G_BLANK = 4'hF;

  logic [3:0]         s1_q, s1_d, s2_q, s2_d;
  logic [3:0]         cand_q, cand_d;
  logic [STAB_W-1:0]  stab_q, stab_d;
  logic [3:0]         disp_q, disp_d;
  logic [7:0]         chg_q, chg_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [1:0]         idx_q, idx_d;
  logic [3:0]         an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;

  logic       disp_ge10;
  logic [3:0] disp_ones;
  logic [3:0] glyph;
  logic [6:0] seg_act;
  logic [3:0] an_act;

  // Synchronizer, debounce qualification and BCD change counter.
  always_comb begin
    s1_d   = code;
    s2_d   = s1_q;
    cand_d = cand_q;
    stab_d = stab_q;
    disp_d = disp_q;
    chg_d  = chg_q;
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      stab_d = '0;
    end else if (stab_q != STAB_MAX) begin
      stab_d = stab_q + STAB_W'(1);
    end else begin
      disp_d = cand_q;
      if (cand_q != disp_q) begin
        if (chg_q[3:0] == 4'd9) begin
          chg_d[3:0] = 4'd0;
          chg_d[7:4] = (chg_q[7:4] == 4'd9) ? 4'd0 : chg_q[7:4] + 4'd1;
        end else begin
          chg_d[3:0] = chg_q[3:0] + 4'd1;
        end
      end
    end
  end

  // Slot prescaler and digit index.
  always_comb begin
    presc_d = presc_q + PRESC_W'(1);
    idx_d   = idx_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end
  end

  // Select the glyph for the current digit slot.
  always_comb begin
    disp_ge10 = (disp_q >= 4'd10);
    disp_ones = disp_ge10 ? disp_q - 4'd10 : disp_q;
    glyph     = G_BLANK;
    case (idx_q)
      2'd0: glyph = (disp_q == 4'hF) ? G_E : disp_ones;
      2'd1: glyph = (disp_q == 4'hF) ? G_DASH : (disp_ge10 ? 4'd1 : G_BLANK);
      2'd2: glyph = chg_q[3:0];
      default: glyph = chg_q[7:4];
    endcase
  end

  // Glyph to active-high segment pattern {g,f,e,d,c,b,a}.
  always_comb begin
    seg_act = 7'h00;
    case (glyph)
      4'd0:    seg_act = 7'h3F;
      4'd1:    seg_act = 7'h06;
      4'd2:    seg_act = 7'h5B;
      4'd3:    seg_act = 7'h4F;
      4'd4:    seg_act = 7'h66;
      4'd5:    seg_act = 7'h6D;
      4'd6:    seg_act = 7'h7D;
      4'd7:    seg_act = 7'h07;
      4'd8:    seg_act = 7'h7F;
      4'd9:    seg_act = 7'h6F;
      G_E:     seg_act = 7'h79;
      G_DASH:  seg_act = 7'h40;
      default: seg_act = 7'h00;
    endcase
  end

  // Output drive with anti-ghosting blank window and polarity.
  always_comb begin
    an_act = (presc_q < BLANK_END) ? 4'b0000 : (4'b0001 << idx_q);
    an_d   = an_act ^ {4{INV}};
    seg_d  = seg_act ^ {7{INV}};
    dp_d   = (idx_q == 2'd2) ^ INV;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      cand_q  <= '0;
      stab_q  <= '0;
      disp_q  <= '0;
      chg_q   <= '0;
      presc_q <= '0;
      idx_q   <= '0;
      an_q    <= {4{INV}};
      seg_q   <= {7{INV}};
      dp_q    <= INV;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      cand_q  <= cand_d;
      stab_q  <= stab_d;
      disp_q  <= disp_d;
      chg_q   <= chg_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign disp_code = disp_q;
  assign chg_bcd   = chg_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Testbench for seg_scan_display: random/directed code stimulus compared
// every cycle against a decimal, run-length based reference model.
module tb_seg_scan_display;

  localparam int SCAN_DIV   = 8;
  localparam int BLANK_CYC  = 2;
  localparam int STABLE_CYC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] code = 4'd0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] disp_code;
  logic [7:0] chg_bcd;

  seg_scan_display #(
    .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC),
    .STABLE_CYC(STABLE_CYC), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .code(code), .an(an), .seg(seg), .dp(dp),
    .disp_code(disp_code), .chg_bcd(chg_bcd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Active-high patterns: index 0..9 digits, 10 'E', 11 '-', 12 blank.
  logic [6:0] pat [13] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D,
                           7'h07, 7'h7F, 7'h6F, 7'h79, 7'h40, 7'h00};

  // Reference model state.
  int         dq[$];
  int         run_val, run_len, m_disp, m_cnt, ncyc;
  int         p, slot, g, v;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;

  // Model: s2 is the code two edges late; a value is accepted once it has been
  // seen for STABLE_CYC+1 consecutive s2 samples. Reset acts as a load of 0.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq = '{0, 0};
      run_val = 0; run_len = 1; m_disp = 0; m_cnt = 0; ncyc = 0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      p    = ncyc % SCAN_DIV;
      slot = (ncyc / SCAN_DIV) % 4;
      case (slot)
        0: g = (m_disp == 15) ? 10 : m_disp % 10;
        1: g = (m_disp == 15) ? 11 : ((m_disp / 10 == 0) ? 12 : m_disp / 10);
        2: g = m_cnt % 10;
        default: g = m_cnt / 10;
      endcase
      e_seg = ~pat[g];
      e_an  = (p < BLANK_CYC) ? 4'hF : ~(4'(1) << slot);
      e_dp  = (slot != 2);
      ncyc++;
      v = dq.pop_front();
      dq.push_back(int'(code));
      if (v == run_val) run_len++;
      else begin run_val = v; run_len = 1; end
      if (run_len >= STABLE_CYC + 1) begin
        if (run_val != m_disp) m_cnt = (m_cnt + 1) % 100;
        m_disp = run_val;
      end
    end
  end

  bit chk_en = 1'b0;

  // Compare all outputs away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("an", 32'(an), 32'(e_an));
      check("seg", 32'(seg), 32'(e_seg));
      check("dp", 32'(dp), 32'(e_dp));
      check("disp_code", 32'(disp_code), 32'(m_disp));
      check("chg_bcd", 32'(chg_bcd), 32'(((m_cnt / 10) << 4) | (m_cnt % 10)));
    end
  end

  task automatic hold(input logic [3:0] c, input int cycles);
    code = c;
    repeat (cycles) @(negedge clk);
  endtask

  int valid_codes[12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 15};

  initial begin
    // Release reset and run briefly with code 7, then reset mid-slot.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    hold(4'd7, 13);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_disp", 32'(disp_code), 32'h0);
    check("rst_chg", 32'(chg_bcd), 32'h00);
    repeat (4) @(negedge clk);
    check("rst_hold_an", 32'(an), 32'hF);
    check("rst_hold_disp", 32'(disp_code), 32'h0);
    code = 4'd0;
    rst_n = 1'b1;

    // 0 -> 3 held: acceptance latency and one counted change.
    hold(4'd0, 2);
    hold(4'd3, 6);
    check("lat_before", 32'(disp_code), 32'h0);
    @(negedge clk);
    check("lat_at7", 32'(disp_code), 32'h3);
    hold(4'd3, 40);

    // Short glitch to 5 must not be accepted or counted.
    hold(4'd5, 3);
    hold(4'd3, 20);
    check("glitch_disp", 32'(disp_code), 32'h3);
    check("glitch_chg", 32'(chg_bcd), 32'h01);

    // Two-digit code and the invalid-pattern override.
    hold(4'd10, 40);
    hold(4'd15, 40);
    check("ovr_chg", 32'(chg_bcd), 32'h03);

    // Randomized code sequences with random hold lengths.
    for (int i = 0; i < 250; i++)
      hold(4'(valid_codes[$urandom_range(11, 0)]), int'($urandom_range(12, 1)));

    // 100 alternating accepted changes wrap the counter through 99 -> 00.
    for (int i = 0; i < 100; i++) hold((i % 2 == 0) ? 4'd1 : 4'd2, 8);
    hold(4'd2, 40);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
